// File: rtl/matrix_result_reader.sv
// matrix_result_reader: tags multiplier products with their row/column
// position and buffers them in an 8-deep FIFO for the reading side.
// Optional per-row product sum is built when MATRIX_RESULT_ROW_SUM_EN is
// defined; otherwise row_sum/row_sum_valid are tied to 0.
module matrix_result_reader (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p_valid,
    input  logic [15:0] p_data,
    input  logic        row_done,
    input  logic        rd_en,
    input  logic        clr,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        empty,
    output logic        full,
    output logic        overflow,
    output logic [3:0]  count,
    output logic [7:0]  rows_done,
    output logic [23:0] row_sum,
    output logic        row_sum_valid
);

    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 3;
    localparam int unsigned CW    = 4;
    localparam int unsigned DW    = 16;
    localparam int unsigned IW    = 8;
    localparam int unsigned EW    = 32;

    // Storage and FIFO bookkeeping
    logic [EW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_empty;
    logic          r_full;

    // Read port registers
    logic [EW-1:0] r_rd_data;
    logic          r_rd_valid;

    // Position tracking and status
    logic          r_overflow;
    logic [IW-1:0] r_row_idx;
    logic [IW-1:0] r_col_idx;
    logic [IW-1:0] r_rows_done;

    // Per-cycle handshake decisions
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [CW-1:0] w_count_next;
    logic [EW-1:0] w_entry;

    // Decide pop/push/drop; a pop frees the slot a full-FIFO push needs
    always_comb begin
        w_pop   = rd_en && !r_empty;
        w_push  = p_valid && (!r_full || w_pop);
        w_drop  = p_valid && !w_push;
        w_entry = {r_row_idx, r_col_idx, p_data[DW-1:0]};
    end

    // Occupancy after this cycle's push/pop
    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - CW'(1);
        end
    end

    // Entry storage; contents are don't-care while the FIFO is empty
    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    // Pointers, occupancy flags and registered read port
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + AW'(1);
                r_rd_data <= r_mem[r_rd_ptr];
            end
            r_rd_valid <= w_pop;
            r_count    <= w_count_next;
            r_empty    <= (w_count_next == CW'(0));
            r_full     <= (w_count_next == CW'(DEPTH));
        end
    end

    // Row/column indices, completed-row count and sticky overflow
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_row_idx   <= '0;
            r_col_idx   <= '0;
            r_rows_done <= '0;
            r_overflow  <= 1'b0;
        end else if (clr) begin
            r_row_idx   <= '0;
            r_col_idx   <= '0;
            r_rows_done <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (row_done) begin
                r_col_idx   <= '0;
                r_row_idx   <= r_row_idx + IW'(1);
                r_rows_done <= r_rows_done + IW'(1);
            end else if (p_valid) begin
                r_col_idx <= r_col_idx + IW'(1);
            end
        end
    end

    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign empty     = r_empty;
    assign full      = r_full;
    assign overflow  = r_overflow;
    assign count     = r_count;
    assign rows_done = r_rows_done;

`ifdef MATRIX_RESULT_ROW_SUM_EN
    localparam int unsigned SW = 24;

    logic [SW-1:0] r_acc;
    logic [SW-1:0] r_row_sum;
    logic          r_row_sum_valid;
    logic [SW-1:0] w_acc_next;

    // Running row total including this cycle's product (dropped or not)
    always_comb begin
        w_acc_next = r_acc + (p_valid ? SW'(p_data) : SW'(0));
    end

    // Close the row on row_done: publish the total and restart from 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc           <= '0;
            r_row_sum       <= '0;
            r_row_sum_valid <= 1'b0;
        end else if (clr) begin
            r_acc           <= '0;
            r_row_sum_valid <= 1'b0;
        end else if (row_done) begin
            r_acc           <= '0;
            r_row_sum       <= w_acc_next;
            r_row_sum_valid <= 1'b1;
        end else begin
            r_acc           <= w_acc_next;
            r_row_sum_valid <= 1'b0;
        end
    end

    assign row_sum       = r_row_sum;
    assign row_sum_valid = r_row_sum_valid;
`else
    assign row_sum       = '0;
    assign row_sum_valid = 1'b0;
`endif

endmodule

// File: doc/matrix_result_reader.md
MATRIX_RESULT_READER -- requirements
Module: matrix_result_reader

Interface
REQ-001 The block SHALL provide the following ports: clk, input, 1 bit, rising-edge clock.
REQ-002 The block SHALL provide rst_n, input, 1 bit; reset rst_n, synchronous, active-low; clock clk.
REQ-003 The block SHALL provide p_valid, input, 1 bit: the multiplier product on p_data is valid this cycle.
REQ-004 The block SHALL provide p_data, input, 16 bits: unsigned multiplier product P.
REQ-005 The block SHALL provide row_done, input, 1 bit: single-cycle pulse marking the end of a result row.
REQ-006 The block SHALL provide rd_en, input, 1 bit: pop request from the reading side.
REQ-007 The block SHALL provide rd_data, output, 32 bits, laid out as {row_idx[7:0], col_idx[7:0], product[15:0]}.
REQ-008 The block SHALL provide rd_valid, output, 1 bit: rd_data carries a popped entry this cycle.
REQ-009 The block SHALL provide empty, full and overflow as 1-bit outputs, and count as a 4-bit output.
REQ-010 The block SHALL provide rows_done, output, 8 bits: count of completed rows.
REQ-011 The block SHALL provide clr, input, 1 bit: clears overflow, rows_done and the row/column indices.
REQ-012 The block SHALL provide row_sum, output, 24 bits, and row_sum_valid, output, 1 bit (see Configuration).

Function
REQ-013 The buffer SHALL be a FIFO of depth 8 holding 32-bit entries.
REQ-014 count SHALL equal the number of stored entries (0..8), with empty = (count==0) and full = (count==8).
REQ-015 A push SHALL occur when p_valid=1 and either full=0 or a pop is accepted in the same cycle.
REQ-016 A pop SHALL occur when rd_en=1 and empty=0.
REQ-017 A simultaneous push and pop SHALL leave count unchanged.
REQ-018 When p_valid=1, full=1 and no pop is accepted, the product SHALL be dropped, overflow SHALL be set (sticky) and FIFO contents SHALL be unchanged.
REQ-019 Each stored entry SHALL capture the current row_idx and col_idx; col_idx SHALL increment after every p_valid, whether the product is accepted or dropped.
REQ-020 On row_done, col_idx SHALL reset to 0, and row_idx and rows_done SHALL each increment, wrapping 255 to 0.
REQ-021 When p_valid and row_done coincide, the product SHALL be tagged with the pre-update indices, and the indices SHALL then advance per REQ-020.
REQ-022 rd_data and rd_valid=1 SHALL be registered, appearing one cycle after the accepted pop.
REQ-023 rd_en on an empty FIFO SHALL be ignored: no pointer change, rd_valid=0 next cycle, no error flag.
REQ-024 rd_data SHALL hold its last value when rd_valid=0.
REQ-025 Pointers SHALL wrap modulo 8.
REQ-026 clr SHALL NOT affect FIFO contents or pointers.
REQ-027 When clr coincides with p_valid, the entry SHALL be tagged with the pre-clear indices.
REQ-028 When clr coincides with row_done, clr SHALL take priority.

Reset
REQ-029 While rst_n=0 at a clk edge, the block SHALL empty the FIFO and clear row_idx, col_idx, rows_done, overflow, rd_valid, rd_data, row_sum and row_sum_valid to 0.
REQ-030 After reset, empty SHALL be 1, and full and count SHALL be 0.
REQ-031 Reset asserted mid-row SHALL discard the partial row and its sum.
REQ-032 The first p_valid after reset release SHALL be tagged row 0, column 0.

Configuration
REQ-033 The feature SHALL be controlled by the macro MATRIX_RESULT_ROW_SUM_EN.
REQ-034 With MATRIX_RESULT_ROW_SUM_EN defined, the block SHALL accumulate, in 24 bits, the p_data of every p_valid in the current row, dropped products included.
REQ-035 With MATRIX_RESULT_ROW_SUM_EN defined, the cycle after row_done the block SHALL present the total on row_sum with row_sum_valid=1 for one cycle, then restart the accumulator at 0.
REQ-036 With MATRIX_RESULT_ROW_SUM_EN defined, a p_valid coinciding with row_done SHALL be included in the closing row's sum.
REQ-037 With MATRIX_RESULT_ROW_SUM_EN defined, clr SHALL also zero the accumulator.
REQ-038 Without MATRIX_RESULT_ROW_SUM_EN, the ports row_sum and row_sum_valid SHALL remain present and be tied to 0, and no accumulator logic SHALL be built.

Verification
REQ-039 Push 3 products 0x0010, 0x0020, 0x0030, then pop 3 -> rd_data = 0x00000010, 0x00010020, 0x00020030, each with rd_valid one cycle after rd_en, and empty=1 afterwards.
REQ-040 Push 10 products with no reads -> full=1 after the 8th push, overflow=1, count=8; pops return columns 0..7 only.
REQ-041 With full=1, assert p_valid and rd_en together -> count stays 8, overflow stays 0, and the new entry is stored as the last one.
REQ-042 Push 0x1234 with row_done in the same cycle, then push 0x0001 -> entries read back 0x00001234 and 0x01000001, and rows_done=1.
REQ-043 With the macro defined, row products 0xFFFF x 4 followed by row_done -> row_sum=0x03FFFC with row_sum_valid pulsed for one cycle; without the macro, row_sum stays 0.
REQ-044 Assert rst_n=0 after 5 pushes, then release -> count=0, empty=1, rd_valid=0, and the next push is tagged row 0, column 0.
